// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: shared types and constants for the DSP48A1 MAC sequencer.
//   state_t   - sequencer FSM states
//   OPM_*     - DSP48A1 OPMODE encodings used by the sequencer
//   tag_t     - per-operand tag travelling alongside the slice pipeline
//   make_tag  - builds the tag pushed for the current cycle
package dsp_seq_pkg;

    localparam int unsigned OPND_W = 18;
    localparam int unsigned P_W    = 48;
    localparam int unsigned OPM_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [OPM_W-1:0] OPM_IDLE   = 8'h00;  // no post-adder update
    localparam logic [OPM_W-1:0] OPM_LOAD_M = 8'h01;  // P = M
    localparam logic [OPM_W-1:0] OPM_ACC_M  = 8'h09;  // P = P + M

    typedef struct packed {
        logic              valid;
        logic [OPM_W-1:0]  op;
    } tag_t;

    // Invalid tags carry OPM_IDLE so the pipe output can drive OPMODE directly.
    function automatic tag_t make_tag(input logic fire, input logic first);
        tag_t t;
        t.valid = fire;
        if (!fire)
            t.op = OPM_IDLE;
        else if (first)
            t.op = OPM_LOAD_M;
        else
            t.op = OPM_ACC_M;
        return t;
    endfunction

endpackage

// File: rtl/dsp_seq_tag_pipe.sv
// dsp_seq_tag_pipe: PIPE_LAT-stage shift register of tags that tracks each
// operand pair through the slice's A/B and M registers.
// Ports:
//   CLK      - clock, rising edge
//   RST      - synchronous active-high reset (clears all stages)
//   clr      - synchronous clear (abort)
//   tag_in   - tag pushed every cycle
//   tag_out  - oldest stage; aligned with the product at the post-adder
//   pending  - a valid tag sits in a stage other than the output stage
module dsp_seq_tag_pipe
    import dsp_seq_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic pending
);

    tag_t [PIPE_LAT-1:0] stg;

    generate
        if (PIPE_LAT == 1) begin : g_one
            // Single stage: nothing can be pending behind the output.
            always_ff @(posedge CLK) begin
                if (RST || clr)
                    stg <= '0;
                else
                    stg <= tag_in;
            end
            assign pending = 1'b0;
        end else begin : g_multi
            logic [PIPE_LAT-2:0] vld;

            always_ff @(posedge CLK) begin
                if (RST || clr)
                    stg <= '0;
                else
                    stg <= {stg[PIPE_LAT-2:0], tag_in};
            end

            for (genvar g = 0; g < PIPE_LAT - 1; g++) begin : g_vld
                assign vld[g] = stg[g].valid;
            end
            assign pending = |vld;
        end
    endgenerate

    assign tag_out = stg[PIPE_LAT-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: sequences one DSP48A1 slice (A/B regs, M reg, P reg,
// OPMODEREG=0) through an N-term multiply-accumulate P = sum(A[i]*B[i]).
// Optional build macro: DSP_SEQ_TIMEOUT_EN (abort on input starvation).
// Ports:
//   CLK, RST           - clock; synchronous active-high reset
//   START, LEN         - job start pulse; term count sampled on START
//   IN_VALID/IN_READY  - operand pair handshake (IN_READY combinational)
//   A_IN, B_IN         - signed operands
//   A_OUT, B_OUT       - operands to the slice (combinational pass-through)
//   CEA, CEB           - slice A/B register enables (combinational)
//   CEM, CEP, RSTP     - slice M/P enables and P reset
//   OPMODE             - slice OPMODE
//   P_IN               - slice P output
//   RESULT             - captured accumulation
//   BUSY, DONE, ERR    - status; DONE is a one-cycle pulse
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned PIPE_LAT    = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic [LEN_W-1:0]         LEN,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic signed [OPND_W-1:0] A_IN,
    input  logic signed [OPND_W-1:0] B_IN,
    output logic signed [OPND_W-1:0] A_OUT,
    output logic signed [OPND_W-1:0] B_OUT,
    output logic                     CEA,
    output logic                     CEB,
    output logic                     CEM,
    output logic                     CEP,
    output logic                     RSTP,
    output logic [OPM_W-1:0]         OPMODE,
    input  logic [P_W-1:0]           P_IN,
    output logic [P_W-1:0]           RESULT,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERR
);

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   acc_cnt;
    logic               busy_q;
    logic               done_q;
    logic               rstp_q;
    logic               cem_q;
    logic               err_q;
    logic [P_W-1:0]     result_q;

    logic               fire;
    logic               to_hit;
    tag_t               tag_push;
    tag_t               tag_head;
    logic               pipe_pending;

    // Handshake and slice input side.
    assign IN_READY = (state == ST_STREAM) && (acc_cnt < len_q);
    assign fire     = IN_VALID && IN_READY;
    assign CEA      = fire;
    assign CEB      = fire;
    assign A_OUT    = A_IN;
    assign B_OUT    = B_IN;

    // First accepted term loads P, later terms accumulate.
    assign tag_push = make_tag(fire, acc_cnt == '0);

    dsp_seq_tag_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tag_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (to_hit),
        .tag_in  (tag_push),
        .tag_out (tag_head),
        .pending (pipe_pending)
    );

    // Tag at the pipe head lines up with its product at the post-adder.
    assign CEP    = tag_head.valid;
    assign OPMODE = tag_head.op;

`ifdef DSP_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;

    // Consecutive starved STREAM cycles; any fire restarts the count.
    assign to_hit = IN_READY && !IN_VALID && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK) begin
        if (RST)
            to_cnt <= '0;
        else if ((state != ST_STREAM) || fire || to_hit)
            to_cnt <= '0;
        else if (IN_READY)
            to_cnt <= to_cnt + TO_W'(1);
    end
`else
    logic [31:0] unused_timeout;

    assign to_hit         = 1'b0;
    assign unused_timeout = 32'(TIMEOUT_CYC);
`endif

    // Sequencer FSM with registered status and slice-control outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            acc_cnt  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rstp_q   <= 1'b1;
            cem_q    <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            rstp_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        len_q   <= LEN;
                        acc_cnt <= '0;
                        busy_q  <= 1'b1;
                        cem_q   <= 1'b1;
                        rstp_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state   <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    state <= (len_q == '0) ? ST_CAPTURE : ST_STREAM;
                end
                ST_STREAM: begin
                    if (to_hit) begin
                        // Starvation abort: P cleared, RESULT kept.
                        busy_q <= 1'b0;
                        cem_q  <= 1'b0;
                        done_q <= 1'b1;
                        rstp_q <= 1'b1;
                        err_q  <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (fire) begin
                        acc_cnt <= acc_cnt + LEN_W'(1);
                        if (acc_cnt == len_q - LEN_W'(1))
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave once only the head stage can still hold a tag;
                    // its CEP lands in P before CAPTURE samples P_IN.
                    if (!pipe_pending)
                        state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    result_q <= (len_q == '0) ? '0 : P_IN;
                    done_q   <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    cem_q  <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RSTP   = rstp_q;
    assign CEM    = cem_q;
    assign ERR    = err_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed bench for dsp_mac_sequencer with a
// behavioural DSP48A1 slice model and scoreboards for CEP/OPMODE and DONE.
module tb_dsp_mac_sequencer;

    localparam int unsigned LEN_W    = 8;
    localparam int unsigned PIPE_LAT = 2;
    localparam int unsigned TO_CYC   = 8;

    logic                CLK;
    logic                RST;
    logic                START;
    logic [LEN_W-1:0]    LEN;
    logic                IN_VALID;
    logic                IN_READY;
    logic signed [17:0]  A_IN;
    logic signed [17:0]  B_IN;
    logic signed [17:0]  A_OUT;
    logic signed [17:0]  B_OUT;
    logic                CEA;
    logic                CEB;
    logic                CEM;
    logic                CEP;
    logic                RSTP;
    logic [7:0]          OPMODE;
    logic [47:0]         P_IN;
    logic [47:0]         RESULT;
    logic                BUSY;
    logic                DONE;
    logic                ERR;

    dsp_mac_sequencer #(
        .LEN_W       (LEN_W),
        .PIPE_LAT    (PIPE_LAT),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .LEN      (LEN),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A_IN     (A_IN),
        .B_IN     (B_IN),
        .A_OUT    (A_OUT),
        .B_OUT    (B_OUT),
        .CEA      (CEA),
        .CEB      (CEB),
        .CEM      (CEM),
        .CEP      (CEP),
        .RSTP     (RSTP),
        .OPMODE   (OPMODE),
        .P_IN     (P_IN),
        .RESULT   (RESULT),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural slice: A1/B1 regs, M reg, P reg with RSTP priority.
    logic signed [17:0] a1, b1;
    logic signed [35:0] m_reg;
    logic        [47:0] p_reg;
    always @(posedge CLK) begin
        if (CEA) a1 <= A_OUT;
        if (CEB) b1 <= B_OUT;
        if (CEM) m_reg <= a1 * b1;
        if (RSTP)
            p_reg <= '0;
        else if (CEP) begin
            if (OPMODE == 8'h01)
                p_reg <= {{12{m_reg[35]}}, m_reg};
            else if (OPMODE == 8'h09)
                p_reg <= p_reg + {{12{m_reg[35]}}, m_reg};
            else
                p_reg <= 'x;
        end
    end
    assign P_IN = p_reg;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] op;
    } op_exp_t;

    typedef struct {
        int          cyc;
        logic [47:0] res;
        logic        err;
        logic        busy;
    } res_exp_t;

    op_exp_t  exp_ops[$];
    res_exp_t exp_res[$];
    op_exp_t  mon_op;
    res_exp_t mon_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops scoreboards when the DUT produces CEP or DONE.
    always @(negedge CLK) begin
        if (!RST) begin
            if (CEP) begin
                if (exp_ops.size() == 0)
                    chk("cep_unexpected", 64'(exp_ops.size()), 64'd1);
                else begin
                    mon_op = exp_ops.pop_front();
                    chk("cep_cycle", 64'(cyc), 64'(mon_op.cyc + int'(PIPE_LAT)));
                    chk("opmode", 64'(OPMODE), 64'(mon_op.op));
                end
            end else if (BUSY) begin
                chk("opmode_idle", 64'(OPMODE), 64'd0);
            end
            if (DONE) begin
                if (exp_res.size() == 0)
                    chk("done_unexpected", 64'(exp_res.size()), 64'd1);
                else begin
                    mon_res = exp_res.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_res.cyc));
                    chk("result", 64'(RESULT), 64'(mon_res.res));
                    chk("err_at_done", 64'(ERR), 64'(mon_res.err));
                    chk("busy_at_done", 64'(BUSY), 64'(mon_res.busy));
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_job(input logic [7:0] len, input logic [47:0] res,
                             input int done_off, input logic err, input logic busy);
        res_exp_t e;
        START   = 1'b1;
        LEN     = len;
        e.cyc   = cyc + done_off;
        e.res   = res;
        e.err   = err;
        e.busy  = busy;
        exp_res.push_back(e);
        tick();
        START = 1'b0;
    endtask

    task automatic feed(input logic signed [17:0] a, input logic signed [17:0] b,
                        input int bubbles, input logic [7:0] op);
        op_exp_t e;
        int      got;
        IN_VALID = 1'b0;
        repeat (bubbles) tick();
        A_IN     = a;
        B_IN     = b;
        IN_VALID = 1'b1;
        got      = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (IN_READY === 1'b1) begin
                e.cyc = cyc;
                e.op  = op;
                exp_ops.push_back(e);
                got = 1;
            end
            tick();
            if (got != 0) break;
        end
        IN_VALID = 1'b0;
        chk("feed_accept", 64'(got), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (exp_res.size() == 0 && exp_ops.size() == 0) break;
            tick();
        end
        chk({tag, "_drained"}, 64'(exp_res.size() + exp_ops.size()), 64'd0);
        @(negedge CLK);
        chk({tag, "_busy_after"}, 64'(BUSY), 64'd0);
        tick();
    endtask

    task automatic reset_vec(input string tag);
        logic [16:0] rv;
        rv = {IN_READY, CEA, CEB, CEM, CEP, RSTP, OPMODE, BUSY, DONE, ERR};
        chk({tag, "_ctrl"}, 64'(rv), 64'h0_0800);
        chk({tag, "_result"}, 64'(RESULT), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        START    = 1'b0;
        LEN      = '0;
        IN_VALID = 1'b0;
        A_IN     = '0;
        B_IN     = '0;
        repeat (3) tick();
        @(negedge CLK);
        reset_vec("reset");
        tick();
        RST = 1'b0;
        tick();

        // 2*3 + 4*5 + (-1)*7 = 19, back-to-back pairs
        start_job(8'd3, 48'd19, 3 + int'(PIPE_LAT) + 3, 1'b0, 1'b1);
        feed(18'sd2, 18'sd3, 0, 8'h01);
        feed(18'sd4, 18'sd5, 0, 8'h09);
        feed(-18'sd1, 18'sd7, 0, 8'h09);
        wait_idle("job_b2b");

        // Same job, two bubbles before the second pair
        start_job(8'd3, 48'd19, 3 + int'(PIPE_LAT) + 3 + 2, 1'b0, 1'b1);
        feed(18'sd2, 18'sd3, 0, 8'h01);
        feed(18'sd4, 18'sd5, 2, 8'h09);
        feed(-18'sd1, 18'sd7, 0, 8'h09);
        wait_idle("job_bubble");

        // LEN=0: one RSTP cycle, RESULT forced to 0
        start_job(8'd0, 48'd0, 3, 1'b0, 1'b1);
        @(negedge CLK);
        chk("len0_rstp_clr", 64'(RSTP), 64'd1);
        chk("len0_busy", 64'(BUSY), 64'd1);
        tick();
        @(negedge CLK);
        chk("len0_rstp_after", 64'(RSTP), 64'd0);
        chk("len0_ready", 64'(IN_READY), 64'd0);
        tick();
        wait_idle("job_len0");

        // START during a job is ignored: 3*4 + 5*6 = 42
        start_job(8'd2, 48'd42, 2 + int'(PIPE_LAT) + 3 + 1, 1'b0, 1'b1);
        feed(18'sd3, 18'sd4, 0, 8'h01);
        START = 1'b1;
        LEN   = 8'd7;
        tick();
        START = 1'b0;
        feed(18'sd5, 18'sd6, 0, 8'h09);
        wait_idle("job_restart");
        repeat (4) tick();
        @(negedge CLK);
        chk("restart_ignored_busy", 64'(BUSY), 64'd0);
        tick();

        // Reset during STREAM: reset values, no DONE
        START = 1'b1;
        LEN   = 8'd3;
        tick();
        START = 1'b0;
        feed(18'sd9, 18'sd9, 0, 8'h01);
        exp_ops.delete();
        RST = 1'b1;
        tick();
        @(negedge CLK);
        reset_vec("midrst");
        tick();
        RST = 1'b0;
        repeat (15) tick();
        @(negedge CLK);
        chk("midrst_busy", 64'(BUSY), 64'd0);
        chk("midrst_result", 64'(RESULT), 64'd0);
        tick();

        // Fresh job after the abort
        start_job(8'd3, 48'd19, 3 + int'(PIPE_LAT) + 3, 1'b0, 1'b1);
        feed(18'sd2, 18'sd3, 0, 8'h01);
        feed(18'sd4, 18'sd5, 0, 8'h09);
        feed(-18'sd1, 18'sd7, 0, 8'h09);
        wait_idle("job_after_rst");

        // Back-to-back single-term jobs
        start_job(8'd1, -48'sd51, 1 + int'(PIPE_LAT) + 3, 1'b0, 1'b1);
        feed(18'sd17, -18'sd3, 0, 8'h01);
        wait_idle("job_neg");
        start_job(8'd1, 48'd10000, 1 + int'(PIPE_LAT) + 3, 1'b0, 1'b1);
        feed(18'sd100, 18'sd100, 0, 8'h01);
        wait_idle("job_10000");
        @(negedge CLK);
        chk("result_hold", 64'(RESULT), 64'd10000);
        chk("err_default", 64'(ERR), 64'd0);
        tick();

`ifdef DSP_SEQ_TIMEOUT_EN
        // Starvation: 2 of 4 pairs, abort after TO_CYC idle cycles
        start_job(8'd4, 48'd10000, 3 + int'(TO_CYC) + 1, 1'b1, 1'b0);
        feed(18'sd1, 18'sd1, 0, 8'h01);
        feed(18'sd2, 18'sd2, 0, 8'h09);
        wait_idle("job_timeout");
        @(negedge CLK);
        chk("timeout_err_sticky", 64'(ERR), 64'd1);
        chk("timeout_ready", 64'(IN_READY), 64'd0);
        chk("timeout_result", 64'(RESULT), 64'd10000);
        tick();
        start_job(8'd1, 48'd10, 1 + int'(PIPE_LAT) + 3, 1'b0, 1'b1);
        feed(18'sd2, 18'sd5, 0, 8'h01);
        wait_idle("job_after_timeout");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
